// File: rtl/mips_regfile_mp_pkg.sv
// Shared constants and types for the multi-port MIPS register file.
// Holds default geometry, index/word types and the hard-wired zero register.
package mips_rf_pkg;

  localparam int RF_DATA_W   = 32;
  localparam int RF_NUM_REGS = 32;
  localparam int RF_ADDR_W   = $clog2(RF_NUM_REGS);

  typedef logic [RF_ADDR_W-1:0] reg_idx_t;
  typedef logic [RF_DATA_W-1:0] word_t;

  localparam int ZERO_REG = 0;

  // True for an index that names a real, writable register.
  function automatic logic idx_valid(input int unsigned idx, input int unsigned nregs);
    return (idx != ZERO_REG) && (idx < nregs);
  endfunction

endpackage

// File: rtl/mips_regfile_mp_if.sv
// Bus between decode/issue/writeback (master) and the register file (slave).
// Flat packed vectors; port k occupies slice [k*W +: W].
interface mips_regfile_mp_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 4,
  parameter int NUM_WR   = 2,
  parameter int ADDR_W   = $clog2(NUM_REGS)
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_ready;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic [NUM_WR-1:0]        alloc_en;
  logic [NUM_WR*ADDR_W-1:0] alloc_addr;
  logic [NUM_REGS-1:0]      busy_vec;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
    input  rd_data, rd_ready, busy_vec
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
    output rd_data, rd_ready, busy_vec
  );
endinterface

// File: rtl/mips_regfile_mp_scoreboard.sv
// Per-register busy scoreboard: issue sets, writeback clears, allocation wins
// a same-cycle collision; also provides the registered per-read-port ready.
module mips_rf_scoreboard
  import mips_rf_pkg::*;
#(
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 4,
  parameter int NUM_WR   = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_WR-1:0]        alloc_en,
  input  logic [NUM_WR*ADDR_W-1:0] alloc_addr,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_REGS-1:0]      busy_vec,
  output logic [NUM_RD-1:0]        rd_ready
);

  logic [NUM_REGS-1:0] busy_reg;
  logic [NUM_REGS-1:0] busy_next;

  // Clears are applied first so a same-cycle allocation overrides them.
  always_comb begin
    busy_next = busy_reg;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j] && idx_valid(32'(wr_addr[j*ADDR_W +: ADDR_W]), NUM_REGS))
        busy_next[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b0;
    end
    for (int j = 0; j < NUM_WR; j++) begin
      if (alloc_en[j] && idx_valid(32'(alloc_addr[j*ADDR_W +: ADDR_W]), NUM_REGS))
        busy_next[alloc_addr[j*ADDR_W +: ADDR_W]] = 1'b1;
    end
    busy_next[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) busy_reg <= '0;
    else          busy_reg <= busy_next;
  end

  assign busy_vec = busy_reg;

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_ready
    logic [ADDR_W-1:0] addr;
    assign addr         = rd_addr[gi*ADDR_W +: ADDR_W];
    assign rd_ready[gi] = idx_valid(32'(addr), NUM_REGS) ? ~busy_reg[addr] : 1'b1;
  end

endmodule

// File: rtl/mips_regfile_mp.sv
// Multi-port MIPS register file: async reads, prioritised sync writes, busy scoreboard.
// Optional write-through forwarding when MIPS_RF_BYPASS_EN is defined.
module mips_regfile_mp
  import mips_rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 4,
  parameter int NUM_WR   = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  mips_regfile_mp_if.slave bus
);

  logic [DATA_W-1:0] rf_reg [NUM_REGS];
  logic [NUM_RD-1:0] sb_ready;

  // Register 0 is never written, so it holds its reset value of zero.
  // Later loop iterations win, giving the highest-index port priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_REGS; r++) rf_reg[r] <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (bus.wr_en[j] && idx_valid(32'(bus.wr_addr[j*ADDR_W +: ADDR_W]), NUM_REGS))
          rf_reg[bus.wr_addr[j*ADDR_W +: ADDR_W]] <= bus.wr_data[j*DATA_W +: DATA_W];
      end
    end
  end

  mips_rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .NUM_WR   (NUM_WR)
  ) u_scoreboard (
    .clk        (clk),
    .reset_n    (reset_n),
    .alloc_en   (bus.alloc_en),
    .alloc_addr (bus.alloc_addr),
    .wr_en      (bus.wr_en),
    .wr_addr    (bus.wr_addr),
    .rd_addr    (bus.rd_addr),
    .busy_vec   (bus.busy_vec),
    .rd_ready   (sb_ready)
  );

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              ready;

    assign addr = bus.rd_addr[gi*ADDR_W +: ADDR_W];

    always_comb begin
      data  = idx_valid(32'(addr), NUM_REGS) ? rf_reg[addr] : '0;
      ready = sb_ready[gi];
`ifdef MIPS_RF_BYPASS_EN
      begin
        logic fwd_hit;
        logic alloc_hit;
        fwd_hit   = 1'b0;
        alloc_hit = 1'b0;
        if (idx_valid(32'(addr), NUM_REGS)) begin
          for (int j = 0; j < NUM_WR; j++) begin
            if (bus.wr_en[j] && bus.wr_addr[j*ADDR_W +: ADDR_W] == addr) begin
              data    = bus.wr_data[j*DATA_W +: DATA_W];
              fwd_hit = 1'b1;
            end
            if (bus.alloc_en[j] && bus.alloc_addr[j*ADDR_W +: ADDR_W] == addr)
              alloc_hit = 1'b1;
          end
        end
        // A same-cycle allocation means a newer producer is still outstanding.
        if (fwd_hit && !alloc_hit) ready = 1'b1;
      end
`endif
    end

    assign bus.rd_data[gi*DATA_W +: DATA_W] = data;
    assign bus.rd_ready[gi]                 = ready;
  end

endmodule

// File: tb/tb_mips_regfile_mp.sv
// Directed-vector bench for mips_regfile_mp: the driver queues expected values,
// a negedge monitor pops and compares them against the live DUT outputs.
module tb_mips_regfile_mp;
  import mips_rf_pkg::*;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  mips_regfile_mp_if #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(4), .NUM_WR(2)) bus ();
  mips_regfile_mp_if #(.DATA_W(32), .NUM_REGS(24), .NUM_RD(2), .NUM_WR(1)) sbus ();

  mips_regfile_mp #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(4), .NUM_WR(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  mips_regfile_mp #(.DATA_W(32), .NUM_REGS(24), .NUM_RD(2), .NUM_WR(1)) dut_small (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (sbus)
  );

  // kind: 0 rd_data[idx], 1 rd_ready[idx], 2 busy_vec[idx], 3 whole busy_vec
  typedef struct {
    string       name;
    int          unit;
    int          kind;
    int          idx;
    logic [31:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic logic [31:0] actual(exp_t e);
    if (e.unit == 0) begin
      case (e.kind)
        0:       return bus.rd_data[e.idx*32 +: 32];
        1:       return 32'(bus.rd_ready[e.idx]);
        2:       return 32'(bus.busy_vec[e.idx]);
        default: return bus.busy_vec;
      endcase
    end else begin
      case (e.kind)
        0:       return sbus.rd_data[e.idx*32 +: 32];
        1:       return 32'(sbus.rd_ready[e.idx]);
        2:       return 32'(sbus.busy_vec[e.idx]);
        default: return 32'(sbus.busy_vec);
      endcase
    end
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        exp_t e;
        logic [31:0] a;
        e = exp_q.pop_front();
        a = actual(e);
        n_vec++;
        if (a !== e.exp) begin
          n_bad++;
          $display("FAIL %s: got %h, expected %h", e.name, a, e.exp);
        end else begin
          $display("ok   %s: %h", e.name, a);
        end
      end
    end
  end

  task automatic push(string n, int u, int kind, int idx, logic [31:0] v);
    exp_t e;
    e.name = n; e.unit = u; e.kind = kind; e.idx = idx; e.exp = v;
    exp_q.push_back(e);
  endtask

  task automatic exp_d(string n, int k, logic [31:0] v);   push(n, 0, 0, k, v); endtask
  task automatic exp_r(string n, int k, logic v);          push(n, 0, 1, k, 32'(v)); endtask
  task automatic exp_bit(string n, int r, logic v);        push(n, 0, 2, r, 32'(v)); endtask
  task automatic exp_busy(string n, logic [31:0] v);       push(n, 0, 3, 0, v); endtask

  task automatic idle();
    bus.rd_addr  = '0; bus.wr_en    = '0; bus.wr_addr    = '0;
    bus.wr_data  = '0; bus.alloc_en = '0; bus.alloc_addr = '0;
    sbus.rd_addr = '0; sbus.wr_en   = '0; sbus.wr_addr   = '0;
    sbus.wr_data = '0; sbus.alloc_en = '0; sbus.alloc_addr = '0;
  endtask

  task automatic rd(int k, int a);
    bus.rd_addr[k*5 +: 5] = 5'(a);
  endtask

  task automatic wr(int j, int a, word_t d);
    bus.wr_en[j]             = 1'b1;
    bus.wr_addr[j*5 +: 5]    = 5'(a);
    bus.wr_data[j*32 +: 32]  = d;
  endtask

  task automatic al(int j, int a);
    bus.alloc_en[j]          = 1'b1;
    bus.alloc_addr[j*5 +: 5] = 5'(a);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    step();
    for (int k = 0; k < 4; k++) begin
      rd(k, k + 1);
      exp_d("por data", k, 32'h0);
      exp_r("por ready", k, 1'b1);
    end
    exp_busy("por busy_vec", 32'h0);
    step();
    reset_n = 1'b1;
    idle();

    // Load r5/r9, then allocate r6
    wr(0, 5, 32'h0000_0055); wr(1, 9, 32'h0000_0099);
    step(); idle();
    rd(0, 5); rd(1, 9);
    exp_d("load r5", 0, 32'h0000_0055);
    exp_d("load r9", 1, 32'h0000_0099);
    al(0, 6);
    step(); idle();
    exp_busy("busy r6 before reset", 32'h0000_0040);
    step();

    // Mid-cycle reset with pending write/alloc held across edges
    reset_n = 1'b0;
    rd(0, 5); rd(1, 9); rd(2, 6);
    wr(0, 5, 32'hFFFF_FFFF); al(1, 9);
    exp_d("reset r5", 0, 32'h0); exp_d("reset r9", 1, 32'h0);
    exp_r("reset ready r6", 2, 1'b1);
    exp_busy("reset busy_vec", 32'h0);
    step(); step();
    idle(); reset_n = 1'b1;
    step();
    rd(0, 5); rd(1, 9);
    exp_d("post-reset r5", 0, 32'h0); exp_d("post-reset r9", 1, 32'h0);
    exp_busy("post-reset busy_vec", 32'h0);

    // Same-address write collision: port 1 wins
    wr(0, 7, 32'hAAAA_0000); wr(1, 7, 32'h5555_1111);
    step(); idle();
    rd(0, 7);
    exp_d("collision r7", 0, 32'h5555_1111);
    exp_r("collision r7 ready", 0, 1'b1);
    wr(0, 0, 32'h1234_5678); wr(1, 0, 32'hFFFF_FFFF);
    step(); idle();
    rd(1, 0);
    exp_d("write r0 ignored", 1, 32'h0);
    exp_r("r0 ready", 1, 1'b1);

    // Scoreboard set / clear
    al(0, 12);
    step(); idle();
    rd(2, 12);
    exp_bit("alloc r12 busy", 12, 1'b1);
    exp_r("alloc r12 ready", 2, 1'b0);
    step(); idle();
    wr(1, 12, 32'hDEAD_BEEF); rd(2, 12);
`ifdef MIPS_RF_BYPASS_EN
    exp_d("wb r12 same-cycle data", 2, 32'hDEAD_BEEF);
    exp_r("wb r12 same-cycle ready", 2, 1'b1);
`else
    exp_d("wb r12 same-cycle data", 2, 32'h0);
    exp_r("wb r12 same-cycle ready", 2, 1'b0);
`endif
    step(); idle();
    rd(2, 12);
    exp_bit("wb r12 busy cleared", 12, 1'b0);
    exp_r("wb r12 ready", 2, 1'b1);
    exp_d("wb r12 data", 2, 32'hDEAD_BEEF);

    // Allocation beats same-cycle clear
    al(0, 3);
    step(); idle();
    al(1, 3); wr(0, 3, 32'h3333_0003);
    step(); idle();
    rd(3, 3);
    exp_bit("alloc/clr r3 busy", 3, 1'b1);
    exp_d("alloc/clr r3 data", 3, 32'h3333_0003);
    exp_r("alloc/clr r3 ready", 3, 1'b0);
    wr(1, 3, 32'h0000_0303);
    step(); idle();
    rd(3, 3);
    exp_bit("clr r3 busy", 3, 1'b0);
    exp_d("clr r3 data", 3, 32'h0000_0303);

    // Clear of non-busy reg and alloc of r0 have no scoreboard effect
    wr(0, 8, 32'h0000_0088); al(1, 0);
    step(); idle();
    rd(0, 8);
    exp_d("r8 data", 0, 32'h0000_0088);
    exp_busy("no-op busy_vec", 32'h0);

    // Double allocation stays busy, one writeback clears
    al(0, 20);
    step(); idle();
    al(0, 20); al(1, 20);
    step(); idle();
    exp_busy("double alloc r20", 32'h0010_0000);
    wr(0, 20, 32'h0000_0020);
    step(); idle();
    exp_bit("r20 cleared", 20, 1'b0);

    // Forwarding window on a busy register
    wr(0, 4, 32'hCAFE_0004);
    step(); idle();
    al(1, 4);
    step(); idle();
    wr(0, 4, 32'h1234_5678); rd(1, 4); rd(3, 4);
`ifdef MIPS_RF_BYPASS_EN
    exp_d("bypass r4 data p1", 1, 32'h1234_5678);
    exp_r("bypass r4 ready p1", 1, 1'b1);
    exp_d("bypass r4 data p3", 3, 32'h1234_5678);
`else
    exp_d("bypass r4 data p1", 1, 32'hCAFE_0004);
    exp_r("bypass r4 ready p1", 1, 1'b0);
    exp_d("bypass r4 data p3", 3, 32'hCAFE_0004);
`endif
    step(); idle();
    rd(1, 4);
    exp_d("r4 after wb", 1, 32'h1234_5678);
    exp_r("r4 ready after wb", 1, 1'b1);

    // NUM_REGS=24 instance: out-of-range address 30
    sbus.wr_en = 1'b1; sbus.wr_addr = 5'd30; sbus.wr_data = 32'h0000_0BAD;
    sbus.alloc_en = 1'b1; sbus.alloc_addr = 5'd30;
    step(); idle();
    push("small busy after oor alloc", 1, 3, 0, 32'h0);
    sbus.wr_en = 1'b1; sbus.wr_addr = 5'd10; sbus.wr_data = 32'h0000_0010;
    sbus.alloc_en = 1'b1; sbus.alloc_addr = 5'd23;
    step(); idle();
    sbus.rd_addr = {5'd10, 5'd30};
    push("small r30 data", 1, 0, 0, 32'h0);
    push("small r30 ready", 1, 1, 0, 32'h1);
    push("small r10 data", 1, 0, 1, 32'h0000_0010);
    push("small busy r23", 1, 3, 0, 32'h0080_0000);
    step();
    sbus.rd_addr = {5'd23, 5'd0};
    push("small r23 ready", 1, 1, 1, 32'h0);
    push("small r0 ready", 1, 1, 0, 32'h1);

    step(); step();
    if (exp_q.size() != 0) begin
      n_bad += exp_q.size();
      $display("FAIL drain: got %0d unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
